parking_occupancy_tracker: RTL and testbench

Parametrised, clocked successor to the combinational parked/empty counter. It synchronises and debounces a vector of per-space occupancy sensors and registers the parked, empty and available counts. An entry-gate request/grant handshake reserves a space per admitted car, and reservations are reclaimed when cars park or a timeout expires. It sits between the raw bay sensors and the entrance barrier/display logic.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/space_debouncer.sv | 66 ++++++
 rtl/parking_occupancy_tracker.sv | 141 ++++++++++++++
 tb/tb_parking_occupancy_tracker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared definitions for the parking occupancy tracker.
//   - gate_state_t  : entry-gate FSM state encoding
//   - count_width() : width needed to hold a count of 0..n
//   - DEF_*         : default parameter values
package parking_pkg;

    localparam int unsigned DEF_SPACES          = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_GRANT_TIMEOUT   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } gate_state_t;

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/space_debouncer.sv
// space_debouncer: per-bay 2-flop synchroniser with optional debounce.
// Build option: PARKING_DEBOUNCE_EN adds a per-bay counter; `stable`
// flips only after DEBOUNCE_CYCLES consecutive synchronised samples
// differ from it. Without it, `stable` is the synchroniser output.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   sensor in  raw bay sensor, asynchronous to clk
//   stable out synchronised (and debounced) occupancy
module space_debouncer
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    output logic stable
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sensor;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PARKING_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] cnt_q;
    logic          stable_q;

    // The counter holds how many consecutive differing samples have
    // been seen; the DEBOUNCE_CYCLES-th one commits the change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync_q2 == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q    <= '0;
            stable_q <= sync_q2;
        end else begin
            cnt_q <= cnt_q + DW'(1);
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync_q2;
`endif

endmodule

// File: rtl/parking_occupancy_tracker.sv
// parking_occupancy_tracker: synchronises/debounces bay sensors, registers
// parked/empty/available counts and runs the entry-gate reservation
// handshake with a reservation timeout.
// Build option: PARKING_DEBOUNCE_EN enables per-bay sensor debounce.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   sensor_i       raw per-bay occupancy, 1 = car present
//   entry_req      gate request (4-phase level handshake)
//   entry_gnt      grant, held until entry_req drops
//   parked         debounced occupied-bay count
//   empty          SPACES - parked
//   available      empty - reserved, floored at 0
//   reserved       outstanding reservations
//   full           available == 0
//   timeout_pulse  one-cycle pulse when reservations expire
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter  int unsigned SPACES          = DEF_SPACES,
    parameter  int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter  int unsigned GRANT_TIMEOUT   = DEF_GRANT_TIMEOUT,
    localparam int unsigned CW              = count_width(SPACES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SPACES-1:0] sensor_i,
    input  logic              entry_req,
    output logic              entry_gnt,
    output logic [CW-1:0]     parked,
    output logic [CW-1:0]     empty,
    output logic [CW-1:0]     available,
    output logic [CW-1:0]     reserved,
    output logic              full,
    output logic              timeout_pulse
);

    localparam int unsigned TW = $clog2(GRANT_TIMEOUT);

    if (SPACES < 1) begin : g_bad_spaces
        $error("SPACES must be at least 1");
    end
    if (GRANT_TIMEOUT < 2) begin : g_bad_timeout
        $error("GRANT_TIMEOUT must be at least 2");
    end

    logic [SPACES-1:0] stable;

    for (genvar i = 0; i < SPACES; i++) begin : g_bay
        space_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk   (clk),
            .rst_n (rst_n),
            .sensor(sensor_i[i]),
            .stable(stable[i])
        );
    end

    logic [CW-1:0] parked_d;
    always_comb begin
        parked_d = '0;
        for (int unsigned i = 0; i < SPACES; i++) begin
            parked_d = parked_d + CW'(stable[i]);
        end
    end

    gate_state_t state_q, state_d;
    logic        grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The reservation is taken on the IDLE->GRANT edge so that reserved
    // and available update on the same edge entry_gnt rises.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        entry_gnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (entry_req && available != '0) begin
                    state_d = GRANT;
                    grant   = 1'b1;
                end
            end
            GRANT: begin
                entry_gnt = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                entry_gnt = 1'b1;
                if (!entry_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] park_inc, dec, base, reserved_d, empty_d, available_d;
    logic [CW:0]   res_sum;
    logic          expire;

    // On expiry the clear wins over any park decrement, then a
    // same-cycle grant is added on top of the cleared value.
    always_comb begin
        park_inc    = (parked_d > parked) ? parked_d - parked : '0;
        dec         = (park_inc < reserved) ? park_inc : reserved;
        expire      = (reserved != '0) && (timer_q == TW'(GRANT_TIMEOUT - 1));
        base        = expire ? '0 : reserved - dec;
        res_sum     = {1'b0, base} + (CW+1)'(grant);
        reserved_d  = (res_sum > (CW+1)'(SPACES)) ? CW'(SPACES) : res_sum[CW-1:0];
        empty_d     = CW'(SPACES) - parked_d;
        available_d = (empty_d > reserved_d) ? empty_d - reserved_d : '0;
        if (grant || dec != '0 || expire) timer_d = '0;
        else if (reserved != '0)          timer_d = timer_q + TW'(1);
        else                              timer_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parked        <= '0;
            empty         <= CW'(SPACES);
            available     <= CW'(SPACES);
            reserved      <= '0;
            timer_q       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            parked        <= parked_d;
            empty         <= empty_d;
            available     <= available_d;
            reserved      <= reserved_d;
            timer_q       <= timer_d;
            timeout_pulse <= expire;
        end
    end

    assign full = (available == '0);

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
module tb_parking_occupancy_tracker;

    localparam int unsigned SPACES = 8;
    localparam int unsigned CW     = 4;
`ifdef PARKING_DEBOUNCE_EN
    localparam int LAT            = 7;
    localparam int GLITCH_FLICKER = 0;
`else
    localparam int LAT            = 3;
    localparam int GLITCH_FLICKER = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [SPACES-1:0] sensor_i = '0;
    logic              entry_req = 1'b0;
    logic              entry_gnt;
    logic [CW-1:0]     parked, empty, available, reserved;
    logic              full, timeout_pulse;

    int checks   = 0;
    int failures = 0;

    parking_occupancy_tracker #(
        .SPACES         (8),
        .DEBOUNCE_CYCLES(4),
        .GRANT_TIMEOUT  (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_i     (sensor_i),
        .entry_req    (entry_req),
        .entry_gnt    (entry_gnt),
        .parked       (parked),
        .empty        (empty),
        .available    (available),
        .reserved     (reserved),
        .full         (full),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_parked"},    32'(parked),        0);
        check_val({pfx, "_empty"},     32'(empty),         8);
        check_val({pfx, "_available"}, 32'(available),     8);
        check_val({pfx, "_reserved"},  32'(reserved),      0);
        check_val({pfx, "_full"},      32'(full),          0);
        check_val({pfx, "_gnt"},       32'(entry_gnt),     0);
        check_val({pfx, "_pulse"},     32'(timeout_pulse), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int flick;
        int n;
        int gnt_seen;

        // Reset state
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Sensor-to-count latency
        sensor_i = 8'h0F;
        repeat (LAT - 1) tick();
        check_val("lat_early_parked", 32'(parked), 0);
        tick();
        check_val("lat_parked", 32'(parked), 4);
        check_val("lat_empty", 32'(empty), 4);
        check_val("lat_available", 32'(available), 4);

        // Two-cycle glitch on bay 7
        sensor_i = 8'h8F;
        tick();
        tick();
        sensor_i = 8'h0F;
        flick = 0;
        repeat (12) begin
            tick();
            if (parked !== 4'd4) flick++;
        end
        check_val("glitch_flicker", 32'(flick), 32'(GLITCH_FLICKER));
        check_val("glitch_parked", 32'(parked), 4);

        // Grant with three empty bays, then a car parks
        sensor_i = 8'h1F;
        repeat (LAT) tick();
        check_val("pre_req_parked", 32'(parked), 5);
        check_val("pre_req_available", 32'(available), 3);
        entry_req = 1'b1;
        tick();
        check_val("grant_gnt", 32'(entry_gnt), 1);
        check_val("grant_reserved", 32'(reserved), 1);
        check_val("grant_available", 32'(available), 2);
        sensor_i = 8'h3F;
        repeat (LAT) tick();
        check_val("park_parked", 32'(parked), 6);
        check_val("park_reserved", 32'(reserved), 0);
        check_val("park_available", 32'(available), 2);
        check_val("park_empty", 32'(empty), 2);
        check_val("hold_gnt", 32'(entry_gnt), 1);
        entry_req = 1'b0;
        tick();
        check_val("release_gnt", 32'(entry_gnt), 0);

        // Nearly full lot: grant makes it full, second request waits for timeout
        sensor_i = 8'h7F;
        repeat (LAT) tick();
        check_val("seven_parked", 32'(parked), 7);
        check_val("seven_available", 32'(available), 1);
        check_val("seven_full", 32'(full), 0);
        entry_req = 1'b1;
        tick();
        check_val("last_grant_gnt", 32'(entry_gnt), 1);
        check_val("last_grant_reserved", 32'(reserved), 1);
        check_val("last_grant_available", 32'(available), 0);
        check_val("last_grant_full", 32'(full), 1);
        entry_req = 1'b0;
        tick();
        tick();
        check_val("holdoff_idle_gnt", 32'(entry_gnt), 0);
        check_val("holdoff_full", 32'(full), 1);
        entry_req = 1'b1;
        n = 2;
        gnt_seen = 0;
        while (timeout_pulse !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (entry_gnt === 1'b1) gnt_seen++;
        end
        check_val("timeout_cycles", 32'(n), 64);
        check_val("holdoff_no_gnt", 32'(gnt_seen), 0);
        check_val("timeout_reserved", 32'(reserved), 0);
        check_val("timeout_full", 32'(full), 0);
        check_val("timeout_available", 32'(available), 1);
        tick();
        check_val("pending_gnt", 32'(entry_gnt), 1);
        check_val("pending_reserved", 32'(reserved), 1);
        check_val("pending_available", 32'(available), 0);

        // Departures leave reservations alone; grant coincides with expiry
        entry_req = 1'b0;
        sensor_i = 8'h0F;
        repeat (LAT) tick();
        check_val("depart_parked", 32'(parked), 4);
        check_val("depart_reserved", 32'(reserved), 1);
        check_val("depart_available", 32'(available), 3);
        entry_req = 1'b1;
        tick();
        check_val("second_res_reserved", 32'(reserved), 2);
        check_val("second_res_available", 32'(available), 2);
        entry_req = 1'b0;
        repeat (63) tick();
        check_val("pre_expiry_reserved", 32'(reserved), 2);
        check_val("pre_expiry_pulse", 32'(timeout_pulse), 0);
        entry_req = 1'b1;
        tick();
        check_val("expiry_grant_reserved", 32'(reserved), 1);
        check_val("expiry_grant_pulse", 32'(timeout_pulse), 1);
        check_val("expiry_grant_gnt", 32'(entry_gnt), 1);
        check_val("expiry_grant_available", 32'(available), 3);

        // Asynchronous reset during HOLD
        tick();
        check_val("hold_before_reset_gnt", 32'(entry_gnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #3;
        rst_n = 1'b1;
        tick();
        check_val("post_reset_gnt", 32'(entry_gnt), 1);
        check_val("post_reset_reserved", 32'(reserved), 1);
        check_val("post_reset_available", 32'(available), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
